ssd_scan_scheduler: RTL and testbench
=====================================

// Module: ssd_scan_scheduler
// PURPOSE
//  Owns the 4-digit seven-segment display: holds a 4-entry digit register file fed by
//  decoded-character write strobes from the UART receive path, time-multiplexes anodes
//  one digit per slot, inserts anti-ghosting blank gaps and applies 16-level brightness PWM.
//  Sits between the ASCII-to-segment decoder and the board pins; all display timing lives here.
// PARAMETERS
//  SLOT_CYCLES   25000  clk cycles per digit slot (4 slots = 1 kHz frame at 100 MHz)
//  BLANK_CYCLES  1000   cycles at start of each slot with all anodes off; (SLOT-BLANK)%16==0
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset, asynchronous, active-high
//  wr_val      in   7  segment pattern to push, active-low {g..a}
//  write       in   1  1-cycle strobe: shift wr_val into digit 0
//  clear       in   1  1-cycle strobe: all digits := SEG_BLANK
//  brightness  in   4  PWM level, 0 = 1/16 on, 15 = full on
//  seg         out  7  segment drive, active-low
//  an          out  4  anode drive, active-low, at most one bit low
//  frame       out  1  1-cycle pulse on last cycle of slot 3
// BEHAVIOUR
//  Reset (async, any state): digit[0..3]=SEG_BLANK(7'h7F), seg=7'h7F, an=4'hF, frame=0,
//   slot idx=0, cycle cnt=0, state=BLANK; cleanly aborts any slot in progress.
//  Register file: write -> digit[3]<=digit[2], [2]<=[1], [1]<=[0], [0]<=wr_val, next edge.
//   clear -> all digits SEG_BLANK next edge; clear and write same cycle: clear wins, write dropped.
//   Back-to-back writes every cycle accepted, no stall, no overflow (oldest digit discarded).
//  Slot timer: cnt 0..SLOT_CYCLES-1, wraps; idx increments 0->1->2->3->0 on wrap.
//   sub_tick every SUB=(SLOT_CYCLES-BLANK_CYCLES)/16 cycles after blank; 4-bit pwm_cnt 0..15.
//  FSM per slot (registered outputs, one cycle after state decision):
//   BLANK: an=4'hF, seg=7'h7F; at cnt==BLANK_CYCLES-1 latch shadow=digit[idx], pwm_cnt=0 -> ON.
//   ON:    an=~(4'b1<<idx), seg=shadow; when pwm_cnt>brightness -> OFF.
//   OFF:   an=4'hF, seg=7'h7F until slot wrap -> BLANK.
//   Slot wrap from ON or OFF -> BLANK; idx advances.
//  Shadow latch: digit value frozen for the slot; updates made mid-slot appear at that
//   digit's next slot start (max latency 4*SLOT_CYCLES+1). No tearing within a slot.
//  brightness sampled combinationally each sub_tick; change takes effect within one sub_tick;
//   level 15 => ON for full post-blank interval, never OFF.
//  frame asserts when idx==3 and cnt==SLOT_CYCLES-1, independent of FSM state.
//  Invariant: an never has more than one bit low; an==4'hF whenever seg==7'h7F is forced.
// CONFIGURATION
//  SSD_PWM_EN defined: brightness PWM as above.
//  SSD_PWM_EN undefined: brightness ignored, pwm_cnt removed, OFF state unreachable;
//   digit ON from BLANK end to slot wrap (equivalent to brightness=15).
// STRUCTURE
//  ssd_pkg: SEG_BLANK=7'h7F, NUM_DIGITS=4, state enum {BLANK,ON,OFF}, digit_idx_t (2 bit).
//  Sub-module ssd_slot_timer: cnt/idx counters, blank_done, sub_tick, slot_wrap, frame.
//  Top holds register file, shadow, FSM and output registers.
// TESTING (SLOT_CYCLES=48, BLANK_CYCLES=16, SUB=2)
//  Reset mid-ON at idx=2 -> same cycle an=4'hF, seg=7'h7F; after release idx 0, BLANK 16 cycles.
//  Write 7'h79,7'h24,7'h30,7'h19 back-to-back, brightness=15 -> slots 0..3 show 19,30,24,79;
//   an=1110,1101,1011,0111; each ON exactly 32 cycles after 16 blank.
//  brightness=0 -> ON 2 cycles per slot then OFF 30; brightness=7 -> ON 16, OFF 16.
//  write+clear same cycle with wr_val=7'h40 -> all digits 7'h7F, no 7'h40 ever displayed.
//  Write during idx=0 ON -> slot 0 keeps old value; new value at next slot-0 start.
//  SSD_PWM_EN undefined, brightness=0 -> ON 32 cycles every slot; frame period 192 cycles.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
// Segment patterns are active-low {g..a}; anodes are active-low.
package ssd_pkg;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam int         NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      ST_BLANK,
      ST_ON,
      ST_OFF
   } ssd_state_t;

   typedef logic [1:0] digit_idx_t;

   // Active-low one-cold anode pattern for a digit position.
   function automatic logic [3:0] anode_sel(digit_idx_t i);
      return ~(4'b0001 << i);
   endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot timing: per-slot cycle counter, digit index, blank end, slot wrap,
// frame pulse and (with SSD_PWM_EN) the PWM sub-tick.
module ssd_slot_timer
   import ssd_pkg::*;
#(
   parameter int SLOT_CYCLES  = 25000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   output digit_idx_t idx,
   output logic       blank_done,
   output logic       slot_wrap,
`ifdef SSD_PWM_EN
   output logic       sub_tick,
`endif
   output logic       frame
);

   localparam int CW = $clog2(SLOT_CYCLES);

   logic [CW-1:0] cnt;

   assign blank_done = (cnt == CW'(BLANK_CYCLES - 1));
   assign slot_wrap  = (cnt == CW'(SLOT_CYCLES - 1));
   assign frame      = slot_wrap && (idx == 2'd3);

   // Cycle counter within the slot; digit index advances on wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_wrap) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

`ifdef SSD_PWM_EN
   localparam int SUB = (SLOT_CYCLES - BLANK_CYCLES) / 16;
   localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;

   logic [SW-1:0] sub_cnt;

   assign sub_tick = (cnt >= CW'(BLANK_CYCLES)) &&
                     (sub_cnt == SW'(SUB - 1));

   // Sub-period counter, phase-locked to the end of the blank gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sub_cnt <= '0;
      else if (cnt < CW'(BLANK_CYCLES) || sub_tick)
         sub_cnt <= '0;
      else
         sub_cnt <= sub_cnt + SW'(1);
   end
`endif

endmodule

// File: rtl/ssd_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: digit register file, slot FSM,
// anti-ghost blanking and brightness PWM (enabled by macro SSD_PWM_EN).
module ssd_scan_scheduler
   import ssd_pkg::*;
#(
   parameter int SLOT_CYCLES  = 25000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] wr_val,
   input  logic       write,
   input  logic       clear,
   input  logic [3:0] brightness,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame
);

   logic [6:0] digit [NUM_DIGITS];
   ssd_state_t state;
   digit_idx_t idx;
   logic       blank_done;
   logic       slot_wrap;

`ifdef SSD_PWM_EN
   logic       sub_tick;
   logic [3:0] pwm_cnt;
`else
   logic       unused_bright;
   assign unused_bright = ^brightness;
`endif

   ssd_slot_timer #(
      .SLOT_CYCLES  (SLOT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .idx        (idx),
      .blank_done (blank_done),
      .slot_wrap  (slot_wrap),
`ifdef SSD_PWM_EN
      .sub_tick   (sub_tick),
`endif
      .frame      (frame)
   );

   // Digit shift register; clear has priority over a same-cycle write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            digit[i] <= SEG_BLANK;
      end else if (clear) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            digit[i] <= SEG_BLANK;
      end else if (write) begin
         for (int i = NUM_DIGITS - 1; i > 0; i--)
            digit[i] <= digit[i-1];
         digit[0] <= wr_val;
      end
   end

   // Slot FSM with registered outputs; seg doubles as the per-slot
   // shadow latch, so mid-slot digit updates never tear the display.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_BLANK;
         seg   <= SEG_BLANK;
         an    <= 4'hF;
`ifdef SSD_PWM_EN
         pwm_cnt <= '0;
`endif
      end else if (slot_wrap) begin
         state <= ST_BLANK;
         seg   <= SEG_BLANK;
         an    <= 4'hF;
      end else begin
         unique case (state)
            ST_BLANK: begin
               if (blank_done) begin
                  state <= ST_ON;
                  seg   <= digit[idx];
                  an    <= anode_sel(idx);
`ifdef SSD_PWM_EN
                  pwm_cnt <= '0;
`endif
               end
            end
            ST_ON: begin
`ifdef SSD_PWM_EN
               if (sub_tick) begin
                  pwm_cnt <= pwm_cnt + 4'd1;
                  if (({1'b0, pwm_cnt} + 5'd1) > {1'b0, brightness}) begin
                     state <= ST_OFF;
                     seg   <= SEG_BLANK;
                     an    <= 4'hF;
                  end
               end
`endif
            end
            ST_OFF: begin
            end
            default: state <= ST_BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler (SLOT_CYCLES=48, BLANK_CYCLES=16).
// Randomized writes/clears/brightness checked against a slot-level model.
module tb_ssd_scan_scheduler;

   localparam int SLOT  = 48;
   localparam int BLANK = 16;
   localparam int SUB   = (SLOT - BLANK) / 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] wr_val = 7'h00;
   logic       write = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] brightness = 4'd15;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ssd_scan_scheduler #(
      .SLOT_CYCLES  (SLOT),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_val     (wr_val),
      .write      (write),
      .clear      (clear),
      .brightness (brightness),
      .seg        (seg),
      .an         (an),
      .frame      (frame)
   );

   // Model state: cycles since reset release, digits, per-slot latch.
   logic [6:0] m_dig [4];
   logic [6:0] m_shadow;
   logic [6:0] seq [4];
   int         t;
   int         b_slot;
   int         ph;
   bit         seen40;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
      end
   endtask

   function automatic bit m_on();
      int c;
      int p;
      c = t % SLOT;
      p = c - BLANK;
      if (c < BLANK) return 1'b0;
`ifdef SSD_PWM_EN
      return p < (b_slot + 1) * SUB;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      t = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 7'h7F;
      m_shadow = 7'h7F;
      b_slot = brightness;
   endtask

   task automatic check_cycle();
      int c;
      int ix;
      logic [3:0] ea;
      logic [6:0] es;
      c  = t % SLOT;
      ix = (t / SLOT) % 4;
      ea = m_on() ? 4'(~(4'b0001 << ix)) : 4'hF;
      es = m_on() ? m_shadow : 7'h7F;
      chk("an", 32'(an), 32'(ea));
      chk("seg", 32'(seg), 32'(es));
      chk("frame", 32'(frame), 32'(ix == 3 && c == SLOT - 1));
      chk("an_onecold", 32'($countones(~an) <= 1), 32'd1);
      if (seg == 7'h40) seen40 = 1'b1;
   endtask

   // Hand-computed expectations that pin the model.
   task automatic lits();
      if (ph != 0) return;
      if (t == 16)  begin chk("lit_s0_seg", 32'(seg), 32'h19); chk("lit_s0_an", 32'(an), 32'hE); end
      if (t == 47)  chk("lit_s0_full", 32'(an), 32'hE);
      if (t == 64)  begin chk("lit_s1_seg", 32'(seg), 32'h30); chk("lit_s1_an", 32'(an), 32'hD); end
      if (t == 112) begin chk("lit_s2_seg", 32'(seg), 32'h24); chk("lit_s2_an", 32'(an), 32'hB); end
      if (t == 160) begin chk("lit_s3_seg", 32'(seg), 32'h79); chk("lit_s3_an", 32'(an), 32'h7); end
      if (t == 191) chk("lit_frame0", 32'(frame), 32'd1);
      if (t == 383) chk("lit_frame1", 32'(frame), 32'd1);
      if (t == 209) chk("lit_b0_on", 32'(an), 32'hE);
`ifdef SSD_PWM_EN
      if (t == 210) chk("lit_b0_off", 32'(an), 32'hF);
      if (t == 416) chk("lit_b7_off", 32'(an), 32'hF);
`else
      if (t == 210) chk("lit_nopwm_on", 32'(an), 32'hE);
      if (t == 416) chk("lit_nopwm_on7", 32'(an), 32'hE);
`endif
      if (t == 415) chk("lit_b7_on", 32'(an), 32'hE);
      if (t == 600) chk("lit_clr_seg", 32'(seg), 32'h7F);
   endtask

   task automatic drive();
      int c;
      c = t % SLOT;
      write = 1'b0;
      clear = 1'b0;
      if (ph == 0) begin
         if (t < 4) begin write = 1'b1; wr_val = seq[t]; end
         if (t == 580) begin write = 1'b1; clear = 1'b1; wr_val = 7'h40; end
         if (c == 0)
            brightness = (t < 192) ? 4'd15 : (t < 384) ? 4'd0 :
                         (t < 576) ? 4'd7 : 4'd15;
      end else begin
         write  = ($urandom % 4) == 0;
         clear  = ($urandom % 64) == 0;
         wr_val = 7'($urandom);
         if (wr_val == 7'h40) wr_val = 7'h41;
         if (c == 0) brightness = (ph == 2) ? 4'd15 : 4'($urandom);
      end
      if (c == 0) b_slot = brightness;
   endtask

   task automatic model_step();
      int c;
      int ix;
      c  = t % SLOT;
      ix = (t / SLOT) % 4;
      if (c == BLANK - 1) m_shadow = m_dig[ix];
      if (clear) begin
         for (int i = 0; i < 4; i++) m_dig[i] = 7'h7F;
      end else if (write) begin
         for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
         m_dig[0] = wr_val;
      end
      t++;
   endtask

   task automatic cycle();
      check_cycle();
      lits();
      drive();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      seq[0] = 7'h79; seq[1] = 7'h24; seq[2] = 7'h30; seq[3] = 7'h19;
      seen40 = 1'b0;
      ph = 0;
      t = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_frame", 32'(frame), 32'd0);
      rst = 1'b0;
      model_reset();

      for (int k = 0; k < 768; k++) cycle();
      ph = 1;
      for (int k = 0; k < 2300; k++) cycle();

      ph = 2;
      found = 1'b0;
      for (int k = 0; k < 600; k++) begin
         if (t % SLOT == 0 && k > 0) ph = 2;
         if ((t / SLOT) % 4 == 2 && t % SLOT == 30 && b_slot == 15) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      chk("reach_mid_on", 32'(found), 32'd1);
      chk("mid_on_an", 32'(an), 32'hB);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_an", 32'(an), 32'hF);
      chk("async_rst_seg", 32'(seg), 32'h7F);
      chk("async_rst_frame", 32'(frame), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      write = 1'b0;
      clear = 1'b0;
      model_reset();
      ph = 1;
      for (int k = 0; k < 400; k++) cycle();

      chk("no_40_shown", 32'(seen40), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
